// File: rtl/prefetch_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_arb_pkg
// Shared types for the prefetch/demand memory arbiter.
//   ADDR_W_DEFAULT : default address width used by addr_t
//   addr_t         : memory address
//   out_entry_t    : outstanding-request table entry {valid, pf, addr}
//   fifo_entry_t   : prefetch FIFO entry {live, addr}
// The stored entry types are built on addr_t, so any ADDR_W override on the
// modules must match ADDR_W_DEFAULT.
// -----------------------------------------------------------------------------
package prefetch_arb_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        logic  pf;
        addr_t addr;
    } out_entry_t;

    typedef struct packed {
        logic  live;
        addr_t addr;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_mem_arbiter_table.sv
// -----------------------------------------------------------------------------
// outstanding_table
// Small CAM that tracks every request issued to memory until its response
// returns.
//   clk, rst_n  : clock, asynchronous active-low reset
//   allocEn     : allocate the lowest-index invalid entry with allocAddr/allocPf
//   freeEn      : invalidate the lowest-index valid entry matching freeAddr
//                 (no match -> ignored)
//   lookupAddr  : address compared against all valid entries
//   lookupHit   : some valid entry holds lookupAddr
//   count       : number of valid entries
// Alloc and free are chosen from the start-of-cycle state, so an entry freed
// this cycle is never the one allocated this cycle.
// -----------------------------------------------------------------------------
module outstanding_table
    import prefetch_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int OUT_DEPTH = 8,
    parameter int CNT_W     = $clog2(OUT_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              allocEn,
    input  logic [ADDR_W-1:0] allocAddr,
    input  logic              allocPf,
    input  logic              freeEn,
    input  logic [ADDR_W-1:0] freeAddr,
    input  logic [ADDR_W-1:0] lookupAddr,
    output logic              lookupHit,
    output logic [CNT_W-1:0]  count
);

    localparam int IDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    out_entry_t       tbl [OUT_DEPTH];
    logic [IDX_W-1:0] allocIdx;
    logic             allocFound;
    logic [IDX_W-1:0] freeIdx;
    logic             freeFound;

    // Priority encoders for alloc/free, CAM lookup and population count.
    always_comb begin
        allocIdx   = '0;
        allocFound = 1'b0;
        freeIdx    = '0;
        freeFound  = 1'b0;
        lookupHit  = 1'b0;
        count      = '0;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (!tbl[i].valid && !allocFound) begin
                allocFound = 1'b1;
                allocIdx   = IDX_W'(i);
            end
            if (tbl[i].valid && (tbl[i].addr == freeAddr) && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (tbl[i].valid && (tbl[i].addr == lookupAddr)) begin
                lookupHit = 1'b1;
            end
            if (tbl[i].valid) begin
                count = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            if (freeEn && freeFound) begin
                tbl[freeIdx].valid <= 1'b0;
            end
            if (allocEn && allocFound) begin
                tbl[allocIdx].valid <= 1'b1;
                tbl[allocIdx].pf    <= allocPf;
                tbl[allocIdx].addr  <= allocAddr;
            end
        end
    end

endmodule

// File: rtl/prefetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// prefetch_mem_arbiter
// Shares one memory request slot between core demand accesses and stride
// prefetches. Prefetches are queued in a small FIFO, deduplicated against the
// FIFO, the outstanding table and the current demand, and throttled by table
// occupancy. Demands win the slot and squash matching queued prefetches.
//   clk, rst_n                : clock, asynchronous active-low reset
//   dmd_valid/dmd_addr        : demand request (held until dmd_ready)
//   dmd_ready                 : demand accepted this cycle
//   pf_valid/pf_addr          : single-cycle prefetch request
//   mem_req_valid/addr/pf     : registered request slot to memory
//   mem_req_ready             : memory takes the slot this cycle
//   mem_resp_valid/addr       : response returning, frees the table entry
//   outst_cnt                 : valid table entries (includes the slot)
//   pf_drop_cnt               : saturating count of dropped prefetches
//   idle                      : nothing queued, in flight or in the slot
// -----------------------------------------------------------------------------
module prefetch_mem_arbiter
    import prefetch_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int PF_DEPTH   = 4,
    parameter int OUT_DEPTH  = 8,
    parameter int PF_MAX_OUT = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dmd_valid,
    input  logic [ADDR_W-1:0]              dmd_addr,
    output logic                           dmd_ready,
    input  logic                           pf_valid,
    input  logic [ADDR_W-1:0]              pf_addr,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic                           mem_req_pf,
    input  logic                           mem_resp_valid,
    input  logic [ADDR_W-1:0]              mem_resp_addr,
    output logic [$clog2(OUT_DEPTH+1)-1:0] outst_cnt,
    output logic [15:0]                    pf_drop_cnt,
    output logic                           idle
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int IDX_W = $clog2(PF_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    fifo_entry_t      fifoQ [PF_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             fifoHit;
    fifo_entry_t      headEntry;

    logic             rstDone;
    logic             slotFree;
    logic             dmdAccept;
    logic             pfPop;
    logic             pfLoad;
    logic             slotLoad;
    logic [ADDR_W-1:0] loadAddr;
    logic             tblHit;
    logic             pfDrop;
    logic             pfPush;

    // Outputs are forced low while in reset; rstDone rises on the first edge
    // after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstDone <= 1'b0;
        end else begin
            rstDone <= 1'b1;
        end
    end

    assign fifoEmpty = (rdPtr == wrPtr);
    assign fifoFull  = (rdPtr[PTR_W-1] != wrPtr[PTR_W-1]) &&
                       (rdPtr[IDX_W-1:0] == wrPtr[IDX_W-1:0]);
    assign headEntry = fifoQ[rdPtr[IDX_W-1:0]];

    always_comb begin
        fifoHit = 1'b0;
        for (int i = 0; i < PF_DEPTH; i++) begin
            if (fifoQ[i].live && (fifoQ[i].addr == pf_addr)) begin
                fifoHit = 1'b1;
            end
        end
    end

    // Slot arbitration: demand first, then FIFO head under the throttle.
    assign slotFree  = !mem_req_valid || mem_req_ready;
    assign dmdAccept = rstDone && slotFree && dmd_valid &&
                       (outst_cnt < CNT_W'(OUT_DEPTH));
    assign dmd_ready = dmdAccept;
    assign pfPop     = rstDone && slotFree && !dmdAccept && !fifoEmpty &&
                       (outst_cnt < CNT_W'(PF_MAX_OUT));
    // A squashed (dead) head is discarded without using the slot.
    assign pfLoad    = pfPop && headEntry.live;
    assign slotLoad  = dmdAccept || pfLoad;
    assign loadAddr  = dmdAccept ? dmd_addr : headEntry.addr;

    // Full is judged on the start-of-cycle pointers even if a pop frees space.
    assign pfDrop = pf_valid && (fifoFull || fifoHit || tblHit ||
                                 (dmd_valid && (dmd_addr == pf_addr)));
    assign pfPush = pf_valid && !pfDrop;

    outstanding_table #(
        .ADDR_W    (ADDR_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .allocEn    (slotLoad),
        .allocAddr  (loadAddr),
        .allocPf    (!dmdAccept),
        .freeEn     (mem_resp_valid),
        .freeAddr   (mem_resp_addr),
        .lookupAddr (pf_addr),
        .lookupHit  (tblHit),
        .count      (outst_cnt)
    );

    // Prefetch FIFO: popped entries are cleared so "live" alone marks the
    // queued addresses used for dedup and squash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            for (int i = 0; i < PF_DEPTH; i++) begin
                fifoQ[i] <= '0;
            end
        end else begin
            if (dmdAccept) begin
                for (int i = 0; i < PF_DEPTH; i++) begin
                    if (fifoQ[i].live && (fifoQ[i].addr == dmd_addr)) begin
                        fifoQ[i].live <= 1'b0;
                    end
                end
            end
            if (pfPop) begin
                fifoQ[rdPtr[IDX_W-1:0]].live <= 1'b0;
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (pfPush) begin
                fifoQ[wrPtr[IDX_W-1:0]].live <= 1'b1;
                fifoQ[wrPtr[IDX_W-1:0]].addr <= pf_addr;
                wrPtr <= wrPtr + PTR_W'(1);
            end
        end
    end

    // Request slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_pf    <= 1'b0;
        end else if (slotLoad) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= loadAddr;
            mem_req_pf    <= !dmdAccept;
        end else if (slotFree) begin
            mem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_drop_cnt <= '0;
        end else if (pfDrop && (pf_drop_cnt != 16'hFFFF)) begin
            pf_drop_cnt <= pf_drop_cnt + 16'd1;
        end
    end

    assign idle = rstDone && fifoEmpty && (outst_cnt == '0) && !mem_req_valid;

endmodule

// File: tb/tb_prefetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prefetch_mem_arbiter
// Directed bench for prefetch_mem_arbiter: reset, priority, dedup, throttle,
// table full, free/squash, backpressure and reset mid-traffic.
// -----------------------------------------------------------------------------
module tb_prefetch_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmd_valid;
    logic [15:0] dmd_addr;
    logic        dmd_ready;
    logic        pf_valid;
    logic [15:0] pf_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_req_pf;
    logic        mem_resp_valid;
    logic [15:0] mem_resp_addr;
    logic [3:0]  outst_cnt;
    logic [15:0] pf_drop_cnt;
    logic        idle;

    int vectors     = 0;
    int miscompares = 0;
    int pfIssues    = 0;
    int issued0300  = 0;
    int issuedPf0400 = 0;

    prefetch_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmd_valid      (dmd_valid),
        .dmd_addr       (dmd_addr),
        .dmd_ready      (dmd_ready),
        .pf_valid       (pf_valid),
        .pf_addr        (pf_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_pf     (mem_req_pf),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_addr  (mem_resp_addr),
        .outst_cnt      (outst_cnt),
        .pf_drop_cnt    (pf_drop_cnt),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    // Count requests actually handed to memory.
    always @(posedge clk) begin
        if (rst_n && mem_req_valid && mem_req_ready) begin
            if (mem_req_pf) pfIssues++;
            if (mem_req_addr == 16'h0300) issued0300++;
            if (mem_req_pf && mem_req_addr == 16'h0400) issuedPf0400++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkSlot(input string tag, input logic v, input logic [15:0] a, input logic p);
        check({tag, "_valid"}, 32'(mem_req_valid), 32'(v));
        check({tag, "_addr"},  32'(mem_req_addr),  32'(a));
        check({tag, "_pf"},    32'(mem_req_pf),    32'(p));
    endtask

    logic [15:0] respList [10];

    initial begin
        respList = '{16'h0100, 16'h0300, 16'h1000, 16'h1001, 16'h1002,
                     16'h2000, 16'h0400, 16'h2001, 16'h2002, 16'h2003};
        rst_n = 1'b0; dmd_valid = 1'b1; dmd_addr = 16'h0055;
        pf_valid = 1'b0; pf_addr = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_addr = '0;
        tick(); tick();
        // In reset: everything low, even with a demand pending.
        check("rst_dmd_ready", 32'(dmd_ready), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        checkSlot("rst", 1'b0, 16'h0000, 1'b0);
        check("rst_cnt", 32'(outst_cnt), 32'd0);
        check("rst_drop", 32'(pf_drop_cnt), 32'd0);
        dmd_valid = 1'b0; rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(idle), 32'd1);

        // Priority: demand and prefetch in the same cycle.
        mem_req_ready = 1'b1;
        dmd_valid = 1'b1; dmd_addr = 16'h0100;
        pf_valid = 1'b1; pf_addr = 16'h0200;
        #1 check("prio_dmd_ready", 32'(dmd_ready), 32'd1);
        tick();
        dmd_valid = 1'b0; pf_valid = 1'b0;
        checkSlot("prio_dmd", 1'b1, 16'h0100, 1'b0);
        check("prio_cnt1", 32'(outst_cnt), 32'd1);
        tick();
        checkSlot("prio_pf", 1'b1, 16'h0200, 1'b1);
        check("prio_cnt2", 32'(outst_cnt), 32'd2);
        tick();
        check("prio_drain", 32'(mem_req_valid), 32'd0);
        check("prio_idle", 32'(idle), 32'd0);

        // Dedup: repeat of a queued address, then an outstanding address.
        pf_valid = 1'b1; pf_addr = 16'h0300;
        tick();
        tick();
        checkSlot("dedup_issue", 1'b1, 16'h0300, 1'b1);
        check("dedup_drop1", 32'(pf_drop_cnt), 32'd1);
        pf_addr = 16'h0100;
        tick();
        pf_valid = 1'b0;
        check("dedup_drop2", 32'(pf_drop_cnt), 32'd2);
        check("dedup_drain", 32'(mem_req_valid), 32'd0);
        tick();
        check("dedup_once", 32'(mem_req_valid), 32'd0);
        check("dedup_cnt", 32'(outst_cnt), 32'd3);

        // Throttle: demands up to 6 outstanding.
        dmd_valid = 1'b1; dmd_addr = 16'h1000;
        tick(); dmd_addr = 16'h1001;
        tick(); dmd_addr = 16'h1002;
        tick(); dmd_valid = 1'b0;
        check("thr_cnt6", 32'(outst_cnt), 32'd6);
        pf_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pf_addr = 16'h2000 + 16'(i);
            tick();
            check("thr_no_pf", 32'(mem_req_valid), 32'd0);
        end
        pf_valid = 1'b0;
        check("thr_full_drop", 32'(pf_drop_cnt), 32'd3);
        check("thr_cnt_hold", 32'(outst_cnt), 32'd6);
        // Demands still go until the table is full.
        dmd_valid = 1'b1; dmd_addr = 16'h1003;
        #1 check("full_dmd_ok", 32'(dmd_ready), 32'd1);
        tick();
        checkSlot("full_dmd7", 1'b1, 16'h1003, 1'b0);
        dmd_addr = 16'h1004;
        tick();
        check("full_cnt8", 32'(outst_cnt), 32'd8);
        dmd_addr = 16'h1005;
        #1 check("full_dmd_block", 32'(dmd_ready), 32'd0);
        tick();
        check("full_drain", 32'(mem_req_valid), 32'd0);
        check("full_dmd_block2", 32'(dmd_ready), 32'd0);

        // Free: responses release entries; the held demand then goes.
        mem_resp_valid = 1'b1; mem_resp_addr = 16'h1003;
        tick();
        check("free_cnt7", 32'(outst_cnt), 32'd7);
        check("free_dmd_ready", 32'(dmd_ready), 32'd1);
        mem_resp_addr = 16'h1004;
        tick();
        dmd_valid = 1'b0;
        checkSlot("free_dmd", 1'b1, 16'h1005, 1'b0);
        check("free_alloc_free", 32'(outst_cnt), 32'd7);
        mem_resp_addr = 16'h0200;
        tick();
        check("free_cnt6", 32'(outst_cnt), 32'd6);
        mem_resp_addr = 16'h1005;
        tick();
        mem_resp_valid = 1'b0;
        check("free_cnt5", 32'(outst_cnt), 32'd5);
        check("free_no_pf_yet", 32'(mem_req_valid), 32'd0);
        tick();
        checkSlot("free_pf_issue", 1'b1, 16'h2000, 1'b1);
        check("free_cnt6b", 32'(outst_cnt), 32'd6);
        tick();
        check("free_throttled", 32'(mem_req_valid), 32'd0);

        // Squash: queue pf 0x0400, then a demand for the same address.
        pf_valid = 1'b1; pf_addr = 16'h0400;
        tick();
        pf_valid = 1'b0;
        check("sq_queued", 32'(pf_drop_cnt), 32'd3);
        dmd_valid = 1'b1; dmd_addr = 16'h0400;
        #1 check("sq_dmd_ready", 32'(dmd_ready), 32'd1);
        tick();
        dmd_valid = 1'b0;
        checkSlot("sq_dmd", 1'b1, 16'h0400, 1'b0);
        check("sq_cnt7", 32'(outst_cnt), 32'd7);
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_resp_addr = respList[i];
            tick();
            if (i == 2) checkSlot("sq_pf2001", 1'b1, 16'h2001, 1'b1);
            if (i == 4) checkSlot("sq_pf2003", 1'b1, 16'h2003, 1'b1);
            if (i == 5) check("sq_dead_pop", 32'(mem_req_valid), 32'd0);
        end
        mem_resp_valid = 1'b0;
        check("sq_idle", 32'(idle), 32'd1);
        check("sq_cnt0", 32'(outst_cnt), 32'd0);
        check("sq_pf0400_never", 32'(issuedPf0400), 32'd0);
        check("dedup_0300_once", 32'(issued0300), 32'd1);
        check("pf_issue_total", 32'(pfIssues), 32'd6);

        // Backpressure, with an unmatched response in flight.
        mem_req_ready = 1'b0;
        dmd_valid = 1'b1; dmd_addr = 16'h0500;
        #1 check("bp_first_ready", 32'(dmd_ready), 32'd1);
        tick();
        dmd_addr = 16'h0501;
        mem_resp_valid = 1'b1; mem_resp_addr = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkSlot("bp_hold", 1'b1, 16'h0500, 1'b0);
            check("bp_dmd_ready", 32'(dmd_ready), 32'd0);
        end
        mem_resp_valid = 1'b0;
        check("bp_unmatched", 32'(outst_cnt), 32'd1);
        mem_req_ready = 1'b1;
        #1 check("bp_release_ready", 32'(dmd_ready), 32'd1);
        tick();
        dmd_valid = 1'b0;
        checkSlot("bp_next", 1'b1, 16'h0501, 1'b0);
        check("bp_cnt2", 32'(outst_cnt), 32'd2);

        // Reset mid-traffic: slot busy, FIFO holding a prefetch.
        mem_req_ready = 1'b0;
        pf_valid = 1'b1; pf_addr = 16'h0600;
        tick();
        pf_valid = 1'b0;
        dmd_valid = 1'b1; dmd_addr = 16'h0700;
        #1 rst_n = 1'b0;
        #1;
        checkSlot("mid_rst", 1'b0, 16'h0000, 1'b0);
        check("mid_rst_cnt", 32'(outst_cnt), 32'd0);
        check("mid_rst_drop", 32'(pf_drop_cnt), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd0);
        check("mid_rst_ready", 32'(dmd_ready), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_addr = 16'h0500;
        tick();
        dmd_valid = 1'b0; mem_req_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("mid_rel_idle", 32'(idle), 32'd1);
        check("mid_rel_cnt", 32'(outst_cnt), 32'd0);
        tick();
        check("mid_rel_no_pf", 32'(mem_req_valid), 32'd0);
        check("mid_rel_idle2", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
